// File: rtl/fpu_pkg.sv
// Shared FPU definitions: float field widths, sticky-flag bit positions and
// the occupancy encoding used by the small writeback buffers.
package fpu_pkg;

  localparam int unsigned SIGN_W = 1;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 23;
  localparam int unsigned WORD_W = SIGN_W + EXP_W + MAN_W;

  localparam int unsigned FLAG_NV = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_ZR = 0;

  typedef logic [3:0] fflags_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/fpu_fifo2.sv
// Two-entry registered FIFO, oldest entry always presented at the head
// register so the output never depends combinationally on the input.
module fpu_fifo2
  import fpu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  occ_e         r_occ;
  occ_e         w_occ_nxt;
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic         w_push;
  logic         w_pop;

  assign o_full  = (r_occ == OCC_FULL);
  assign o_valid = (r_occ != OCC_EMPTY);
  assign o_data  = r_head;
  assign w_push  = i_push && (r_occ != OCC_FULL);
  assign w_pop   = i_pop  && (r_occ != OCC_EMPTY);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_occ <= OCC_EMPTY;
    else       r_occ <= w_occ_nxt;
  end

  always_comb begin
    w_occ_nxt = r_occ;
    case (r_occ)
      OCC_EMPTY: if (w_push) w_occ_nxt = OCC_ONE;
      OCC_ONE: begin
        if (w_push && !w_pop)      w_occ_nxt = OCC_FULL;
        else if (w_pop && !w_push) w_occ_nxt = OCC_EMPTY;
      end
      OCC_FULL:  if (w_pop) w_occ_nxt = OCC_ONE;
      default:   w_occ_nxt = OCC_EMPTY;
    endcase
  end

  // Pop from FULL shifts the tail into the head; push+pop in ONE replaces the head.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_occ)
        OCC_EMPTY: if (w_push) r_head <= i_data;
        OCC_ONE: begin
          if (w_push && w_pop) r_head <= i_data;
          else if (w_push)     r_tail <= i_data;
        end
        OCC_FULL:  if (w_pop) r_head <= r_tail;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fadd_writeback.sv
// FADD result writeback stage: classifies results, keeps sticky flags and a
// retire counter. Define FADD_WB_FTZ_EN to flush denormal results to signed zero.
module fadd_writeback
  import fpu_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_d,
  input  logic              in_overflow,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_d,
  output logic [TAG_W-1:0]  out_tag,
  output logic [3:0]        flags,
  input  logic              flags_clr,
  output logic [15:0]       retired
);

  localparam int unsigned ENT_W = WORD_W + TAG_W;

  logic               w_accept;
  logic               w_retire;
  logic               w_full;
  logic [EXP_W-1:0]   w_exp;
  logic [MAN_W-1:0]   w_man;
  logic               w_exp_max;
  logic               w_exp_zero;
  logic               w_man_zero;
  logic               w_denorm;
  fflags_t            w_eflags;
  logic [WORD_W-1:0]  w_d_buf;
  logic [ENT_W-1:0]   w_fifo_out;
  fflags_t            r_flags;
  logic [15:0]        r_retired;

  assign in_ready = !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_retire = out_valid && out_ready;

  assign w_exp      = in_d[MAN_W +: EXP_W];
  assign w_man      = in_d[MAN_W-1:0];
  assign w_exp_max  = &w_exp;
  assign w_exp_zero = ~|w_exp;
  assign w_man_zero = ~|w_man;
  assign w_denorm   = w_exp_zero && !w_man_zero;

  always_comb begin
    w_eflags          = '0;
    w_eflags[FLAG_NV] = w_exp_max && !w_man_zero;
    w_eflags[FLAG_OF] = in_overflow || (w_exp_max && w_man_zero);
    w_eflags[FLAG_UF] = w_denorm;
    w_eflags[FLAG_ZR] = w_exp_zero && w_man_zero;
  end

`ifdef FADD_WB_FTZ_EN
  assign w_d_buf = w_denorm ? {in_d[WORD_W-1], {(WORD_W-1){1'b0}}} : in_d;
`else
  assign w_d_buf = in_d;
`endif

  fpu_fifo2 #(.W(ENT_W)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_accept),
    .i_data  ({w_d_buf, in_tag}),
    .o_full  (w_full),
    .i_pop   (w_retire),
    .o_valid (out_valid),
    .o_data  (w_fifo_out)
  );

  assign out_d   = w_fifo_out[ENT_W-1:TAG_W];
  assign out_tag = w_fifo_out[TAG_W-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_flags   <= '0;
      r_retired <= '0;
    end else begin
      r_flags <= (flags_clr ? '0 : r_flags) | (w_accept ? w_eflags : '0);
      if (w_retire) r_retired <= r_retired + 16'd1;
    end
  end

  assign flags   = r_flags;
  assign retired = r_retired;

endmodule

// File: doc/fadd_writeback.md
FADD_WRITEBACK -- requirements
Module: fadd_writeback

Interface
REQ-001 SHALL have parameter TAG_W, default 5, destination-register tag width.
REQ-002 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  fadd result present.
REQ-005 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-006 SHALL have port in_d  input  32  fadd result word.
REQ-007 SHALL have port in_overflow  input  1  fadd overflow indication.
REQ-008 SHALL have port in_tag  input  TAG_W  destination tag.
REQ-009 SHALL have port out_valid  output  1  writeback entry valid.
REQ-010 SHALL have port out_ready  input  1  register file accepts.
REQ-011 SHALL have port out_d  output  32  writeback data.
REQ-012 SHALL have port out_tag  output  TAG_W  writeback tag.
REQ-013 SHALL have port flags  output  4  sticky {NV,OF,UF,ZR}.
REQ-014 SHALL have port flags_clr  input  1  clear sticky flags.
REQ-015 SHALL have port retired  output  16  count of completed writebacks.

Function
REQ-016 SHALL accept an entry when in_valid && in_ready (accept) and retire one when out_valid && out_ready (retire).
REQ-017 SHALL buffer accepted entries in a 2-entry FIFO, oldest first; in_ready = FIFO not full, independent of out_ready.
REQ-018 SHALL assert out_valid exactly 1 cycle after accept into an empty FIFO (latency 1, no combinational in-to-out path).
REQ-019 SHALL track occupancy states EMPTY, ONE, FULL: accept-only +1, retire-only -1, accept+retire in ONE stays ONE.
REQ-020 SHALL hold out_d/out_tag stable while out_valid && !out_ready.
REQ-021 SHALL classify in_d at accept: NaN = exp 255 & man!=0; inf = exp 255 & man==0; zero = exp 0 & man 0; denorm = exp 0 & man!=0.
REQ-022 SHALL derive per-entry flags: NV = NaN; OF = in_overflow | inf; UF = denorm; ZR = zero.
REQ-023 SHALL update flags on the clock edge as (flags_clr ? 0 : flags) | (accept ? entry_flags : 0).
REQ-024 SHALL increment retired by 1 per retire, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL ignore in_* when in_valid is low and ignore out_ready when out_valid is low.

Reset
REQ-026 SHALL, on rstn low, immediately clear FIFO to EMPTY, out_valid=0, out_d=0, out_tag=0, flags=0, retired=0; in_ready=1 after reset.
REQ-027 SHALL discard in-flight entries on reset mid-operation; no entry retires in the reset cycle.

Configuration
REQ-028 SHALL, with FADD_WB_FTZ_EN defined, replace denorm in_d with signed zero {sign,31'b0} before buffering, UF still set.
REQ-029 SHALL, without FADD_WB_FTZ_EN, pass denorm in_d unmodified.

Structure
REQ-030 SHALL take flag-index constants, the 4-bit flag typedef and float field widths (1/8/23) from shared package fpu_pkg.
REQ-031 SHALL implement buffering in sub-module fpu_fifo2 (2-entry, parameterised width); classification and counters in the top.

Verification
REQ-032 SHALL cover: accept 0x3F800000 tag 3, out_ready=1 -> next cycle out_d=0x3F800000, out_tag=3, flags=0, retired=1.
REQ-033 SHALL cover: out_ready=0, accept 3 back-to-back -> in_ready low after 2 accepts, third held; then drain in order, retired=2 then 3.
REQ-034 SHALL cover: in_d=0x7FC00000 then 0x7F800000 with in_overflow=1 -> flags=NV|OF; flags_clr with simultaneous accept of 0x00000000 -> flags=ZR.
REQ-035 SHALL cover: in_d=0x80000001 -> out_d=0x80000000 and UF with FADD_WB_FTZ_EN; out_d=0x80000001 and UF without.
REQ-036 SHALL cover: FIFO FULL, assert rstn low mid-cycle -> out_valid=0, in_ready=1, flags=0, retired=0 immediately.
REQ-037 SHALL cover: retired preloaded to 0xFFFF via 65535 retires -> next retire gives 0x0000.
